// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm
//   Instruction control unit for the 9-bit simple processor. Latches an
//   instruction (format IIIXXXYYY: opcode, Rx, Ry) from din when Run is seen
//   in IDLE. It then sequences the instruction over one to three execute
//   cycles (T1..T3) and returns to IDLE. All outputs are Moore decodes of
//   (state, IR); g_nz is the only input with a combinational path to the
//   outputs.
//
//   Optional feature macro: PROC_CTRL_MVNZ_EN
//     defined   -> opcode 100 is MVNZ (conditional move on G != 0)
//     undefined -> opcode 100 is reserved (done-only); g_nz is ignored
//
// Ports
//   Clock   in   system clock, rising edge
//   Resetn  in   asynchronous active-low reset
//   Run     in   start request, sampled only in IDLE
//   din     in   data-in bus, instruction source in IDLE
//   g_nz    in   G nonzero flag (MVNZ only)
//   rsele   out  one-hot register bus-source select (bit i = Ri)
//   gsele   out  G drives bus
//   dsele   out  DIN drives bus
//   rin     out  register load enables (bit i = Ri)
//   ain     out  A load enable
//   gin     out  G load enable
//   addsub  out  ALU op, 0 = add, 1 = sub
//   done    out  final cycle of the current instruction
//   busy    out  state != IDLE
module proc_ctrl_fsm #(
  parameter int IR_W = 9
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IR_W-1:0] din,
  input  logic            g_nz,
  output logic [7:0]      rsele,
  output logic            gsele,
  output logic            dsele,
  output logic [7:0]      rin,
  output logic            ain,
  output logic            gin,
  output logic            addsub,
  output logic            done,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;

  logic [2:0] op;
  logic [7:0] x_oh;
  logic [7:0] y_oh;

  assign op = ir_q[8:6];

  always_comb begin
    x_oh = '0;
    y_oh = '0;
    x_oh[ir_q[5:3]] = 1'b1;
    y_oh[ir_q[2:0]] = 1'b1;
  end

`ifndef PROC_CTRL_MVNZ_EN
  logic unused_g_nz;
  assign unused_g_nz = g_nz;
`endif

  // Next-state and IR load. Only ADD/SUB (01x) continue past T1.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (Run) begin
          ir_d    = din;
          state_d = S_T1;
        end
      end
      S_T1:    state_d = (op[2:1] == 2'b01) ? S_T2 : S_IDLE;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Output decode. Decoding from state_q makes async reset clear every
  // output immediately, without waiting for a clock edge.
  always_comb begin
    rsele  = '0;
    gsele  = 1'b0;
    dsele  = 1'b0;
    rin    = '0;
    ain    = 1'b0;
    gin    = 1'b0;
    addsub = 1'b0;
    done   = 1'b0;
    busy   = (state_q != S_IDLE);
    unique case (state_q)
      S_T1: begin
        unique case (op)
          3'b000: begin
            rsele = y_oh;
            rin   = x_oh;
            done  = 1'b1;
          end
          3'b001: begin
            dsele = 1'b1;
            rin   = x_oh;
            done  = 1'b1;
          end
          3'b010, 3'b011: begin
            rsele = x_oh;
            ain   = 1'b1;
          end
`ifdef PROC_CTRL_MVNZ_EN
          3'b100: begin
            done = 1'b1;
            if (g_nz) begin
              rsele = y_oh;
              rin   = x_oh;
            end
          end
`endif
          default: done = 1'b1;
        endcase
      end
      S_T2: begin
        rsele  = y_oh;
        gin    = 1'b1;
        addsub = op[0];
      end
      S_T3: begin
        gsele = 1'b1;
        rin   = x_oh;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
module tb_proc_ctrl_fsm;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] din;
  logic       g_nz;
  logic [7:0] rsele;
  logic       gsele;
  logic       dsele;
  logic [7:0] rin;
  logic       ain;
  logic       gin;
  logic       addsub;
  logic       done;
  logic       busy;

  proc_ctrl_fsm #(.IR_W(9)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .din    (din),
    .g_nz   (g_nz),
    .rsele  (rsele),
    .gsele  (gsele),
    .dsele  (dsele),
    .rin    (rin),
    .ain    (ain),
    .gin    (gin),
    .addsub (addsub),
    .done   (done),
    .busy   (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Packed output vector: {rsele, gsele, dsele, rin, ain, gin, addsub, done}
  logic [21:0] exp_q[$];
  logic [21:0] obs;
  assign obs = {rsele, gsele, dsele, rin, ain, gin, addsub, done};

  function automatic logic [21:0] mk(input logic [7:0] rs, input logic gs,
                                     input logic ds, input logic [7:0] ri,
                                     input logic a, input logic g,
                                     input logic as, input logic dn);
    return {rs, gs, ds, ri, a, g, as, dn};
  endfunction

  task automatic check(input string name, input logic [22:0] act,
                       input logic [22:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: the list of per-cycle outputs an instruction produces.
  function automatic int push_expected(input logic [8:0] ins, input logic g);
    logic [2:0] op;
    logic [7:0] xo, yo;
    op = ins[8:6];
    xo = 8'd1 << ins[5:3];
    yo = 8'd1 << ins[2:0];
    case (op)
      3'd0: begin exp_q.push_back(mk(yo, 0, 0, xo, 0, 0, 0, 1)); return 1; end
      3'd1: begin exp_q.push_back(mk(0, 0, 1, xo, 0, 0, 0, 1)); return 1; end
      3'd2, 3'd3: begin
        exp_q.push_back(mk(xo, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(mk(yo, 0, 0, 0, 0, 1, (op == 3'd3), 0));
        exp_q.push_back(mk(0, 1, 0, xo, 0, 0, 0, 1));
        return 3;
      end
`ifdef PROC_CTRL_MVNZ_EN
      3'd4: begin
        if (g) exp_q.push_back(mk(yo, 0, 0, xo, 0, 0, 0, 1));
        else   exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        return 1;
      end
`endif
      default: begin exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1)); return 1; end
    endcase
  endfunction

  // Monitor: pops one expectation per busy cycle; IDLE cycles must be quiet.
  always @(negedge Clock) begin
    if (mon_en) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL busy_unexpected actual=busy required=idle");
        end else begin
          check("exec_cycle", {1'b1, obs}, {1'b1, exp_q.pop_front()});
        end
      end else begin
        check("idle_quiet", {busy, obs}, 23'd0);
      end
    end
  end

  // Called in an IDLE cycle (posedge+2); returns in the following IDLE cycle.
  task automatic issue(input logic [8:0] ins, input logic g);
    int n;
    Run  = 1'b1;
    din  = ins;
    g_nz = g;
    n = push_expected(ins, g);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #2;
      Run = 1'($urandom_range(0, 1));
      din = 9'($urandom);
    end
    @(posedge Clock); #2;
    Run = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #2;
      Run = 1'b0;
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b1;
    din    = 9'h050;
    g_nz   = 1'b0;
    mon_en = 1'b1;
    // Reset held with Run=1: monitor sees quiet IDLE each cycle.
    repeat (3) @(posedge Clock);
    #2;
    check("reset_state", {busy, obs}, 23'd0);
    Resetn = 1'b1;
    // 9'h050 is MVI R2: it loads at the first edge after release.
    issue(9'h050, 1'b0);
    idle(1);
    // MVI R2 with a different immediate on din during T1 (driven randomly).
    issue(9'b001_010_000, 1'b0);
    issue(9'b010_001_011, 1'b0);          // ADD R1,R3
    issue(9'b011_111_000, 1'b0);          // SUB R7,R0
    issue(9'b000_000_101, 1'b0);          // MV R0,R5, back-to-back
    issue(9'b000_011_011, 1'b0);          // MV R3,R3
    issue(9'b100_100_110, 1'b1);          // opcode 100, g_nz=1
    issue(9'b100_100_110, 1'b0);          // opcode 100, g_nz=0
    issue(9'b111_001_010, 1'b1);          // reserved
    idle(2);
    for (int k = 0; k < 250; k++) begin
      issue(9'($urandom), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(4);
    check("queue_drained", 23'(exp_q.size()), 23'd0);
    mon_en = 1'b0;

    // Mid-instruction reset during T2 of ADD R1,R3.
    @(posedge Clock); #2;
    Run = 1'b1;
    din = 9'b010_001_011;
    @(posedge Clock); #2;                  // T1
    Run = 1'b0;
    @(posedge Clock); #3;                  // inside T2
    check("add_t2_pre_reset", {busy, obs}, {1'b1, mk(8'h08, 0, 0, 0, 0, 1, 0, 0)});
    Resetn = 1'b0;
    #1;
    check("mid_reset_clear", {busy, obs}, 23'd0);
    @(posedge Clock); #2;
    check("reset_held_idle", {busy, obs}, 23'd0);
    Resetn = 1'b1;
    Run    = 1'b1;
    din    = 9'b000_000_101;               // MV R0,R5
    @(posedge Clock); #2;
    Run = 1'b0;
    check("mv_after_reset", {busy, obs}, {1'b1, mk(8'h20, 0, 0, 8'h01, 0, 0, 0, 1)});
    @(posedge Clock); #2;
    check("idle_after_mv", {busy, obs}, 23'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
